// File: rtl/adder_tree_pkg.sv
// Shared constants and helpers for the pipelined adder tree reduction block.
package adder_tree_pkg;

  // Lane interpretation: zero-extended unsigned or sign-extended two's complement.
  localparam int SIGNED_OFF = 0;
  localparam int SIGNED_ON  = 1;

  // Ceiling log2; clog2(1) = 0 so a single-beat group still gets a 1-bit counter.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Width of one register at tree level 'level': each pairwise add grows by one bit.
  function automatic int level_width(input int in_width, input int level);
    return in_width + level + 1;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: adds adjacent lane pairs and
// carries a valid bit alongside the data.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [LANES*WIDTH-1:0]           in_data,
  output logic [(LANES/2)*(WIDTH+1)-1:0]   out_data,
  output logic                             out_valid
);

  localparam int PAIRS       = LANES / 2;
  localparam bit EXTEND_SIGN = (SIGNED != SIGNED_OFF);

  logic [PAIRS*(WIDTH+1)-1:0] sum_comb;

  for (genvar j = 0; j < PAIRS; j++) begin : g_pair
    logic [WIDTH-1:0] lane_a;
    logic [WIDTH-1:0] lane_b;
    logic [WIDTH:0]   ext_a;
    logic [WIDTH:0]   ext_b;

    assign lane_a = in_data[(2*j)*WIDTH +: WIDTH];
    assign lane_b = in_data[(2*j+1)*WIDTH +: WIDTH];
    assign ext_a  = {EXTEND_SIGN & lane_a[WIDTH-1], lane_a};
    assign ext_b  = {EXTEND_SIGN & lane_b[WIDTH-1], lane_b};
    assign sum_comb[j*(WIDTH+1) +: WIDTH+1] = ext_a + ext_b;
  end

  // Data registers load every cycle; only the valid bit decides whether it matters.
  always_ff @(posedge clk) begin
    out_data <= sum_comb;
  end

  // Valid bit follows the data one level down and is cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

endmodule

// File: rtl/adder_tree_pipelined_acc.sv
// Fully pipelined adder tree over NUM_INPUTS lanes followed by an optional
// group accumulator that emits one result every ACC_LEN tree results.
module adder_tree_pipelined_acc
  import adder_tree_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 32,
  parameter int SIGNED     = 0,
  parameter int ACC_LEN    = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [NUM_INPUTS*IN_WIDTH-1:0] in_data,
  input  logic                           flush,
  output logic                           out_valid,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic [clog2(ACC_LEN):0]        acc_count
);

  localparam int S      = clog2(NUM_INPUTS);
  localparam int TREE_W = level_width(IN_WIDTH, S - 1);
  localparam int CNT_W  = clog2(ACC_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ACC_LEN - 1);

  // Tree levels: level k reduces NUM_INPUTS>>k values of IN_WIDTH+k bits by half.
  for (genvar k = 0; k < S; k++) begin : g_level
    localparam int LANES_IN = NUM_INPUTS >> k;
    localparam int W_IN     = IN_WIDTH + k;
    localparam int W_OUT    = level_width(IN_WIDTH, k);

    logic [(LANES_IN/2)*W_OUT-1:0] data;
    logic                          valid;

    if (k == 0) begin : g_first
      adder_tree_level #(
        .LANES (LANES_IN),
        .WIDTH (W_IN),
        .SIGNED(SIGNED)
      ) u_level (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_data (data),
        .out_valid(valid)
      );
    end else begin : g_next
      adder_tree_level #(
        .LANES (LANES_IN),
        .WIDTH (W_IN),
        .SIGNED(SIGNED)
      ) u_level (
        .clk      (clk),
        .reset    (reset),
        .in_valid (g_level[k-1].valid),
        .in_data  (g_level[k-1].data),
        .out_data (data),
        .out_valid(valid)
      );
    end
  end

  logic [TREE_W-1:0]    tree_sum;
  logic                 tree_valid;
  logic [OUT_WIDTH-1:0] tree_ext;

  assign tree_sum   = g_level[S-1].data;
  assign tree_valid = g_level[S-1].valid;

  // Bring the tree result to the output width: extend per lane signedness, or wrap.
  if (OUT_WIDTH > TREE_W) begin : g_extend
    assign tree_ext = {{(OUT_WIDTH-TREE_W){(SIGNED == SIGNED_ON) & tree_sum[TREE_W-1]}}, tree_sum};
  end else begin : g_truncate
    assign tree_ext = tree_sum[OUT_WIDTH-1:0];
  end

  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] acc_base;
  logic [OUT_WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]     cnt_base;

  // A flush makes the incoming tree result (if any) the first beat of a new group.
  always_comb begin
    acc_base = flush ? '0 : acc;
    cnt_base = flush ? '0 : acc_count;
    acc_next = acc_base + tree_ext;
  end

  // Accumulate tree results and emit the group sum on its last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
      acc_count <= '0;
    end else if (tree_valid) begin
      if (cnt_base == LAST_BEAT) begin
        out_data  <= acc_next;
        out_valid <= 1'b1;
        acc       <= '0;
        acc_count <= '0;
      end else begin
        acc       <= acc_next;
        acc_count <= cnt_base + CNT_W'(1);
        out_valid <= 1'b0;
      end
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        acc       <= '0;
        acc_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_pipelined_acc.sv
// Directed self-checking bench for adder_tree_pipelined_acc: three instances
// (unsigned single-beat, signed single-beat, unsigned 4-beat groups) share stimulus.
module tb_adder_tree_pipelined_acc;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [127:0] in_data;
  logic         flush;

  logic         u_ov;
  logic [31:0]  u_od;
  logic [0:0]   u_ac;
  logic         s_ov;
  logic [31:0]  s_od;
  logic [0:0]   s_ac;
  logic         a_ov;
  logic [31:0]  a_od;
  logic [2:0]   a_ac;

  int checks;
  int failures;

  adder_tree_pipelined_acc #(
    .NUM_INPUTS(8), .IN_WIDTH(16), .OUT_WIDTH(32), .SIGNED(0), .ACC_LEN(1)
  ) u_dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .out_valid(u_ov), .out_data(u_od), .acc_count(u_ac)
  );

  adder_tree_pipelined_acc #(
    .NUM_INPUTS(8), .IN_WIDTH(16), .OUT_WIDTH(32), .SIGNED(1), .ACC_LEN(1)
  ) u_dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .out_valid(s_ov), .out_data(s_od), .acc_count(s_ac)
  );

  adder_tree_pipelined_acc #(
    .NUM_INPUTS(8), .IN_WIDTH(16), .OUT_WIDTH(32), .SIGNED(0), .ACC_LEN(4)
  ) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .out_valid(a_ov), .out_data(a_od), .acc_count(a_ac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    in_data  = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (u_ov !== 1'b0 || u_od !== 32'd0 || u_ac !== 1'd0) begin
      failures++;
      $display("[TB] FAIL reset_u: got ov=%0b od=%0h ac=%0d want 0/0/0", u_ov, u_od, u_ac);
    end
    checks++;
    if (s_ov !== 1'b0 || s_od !== 32'd0 || s_ac !== 1'd0) begin
      failures++;
      $display("[TB] FAIL reset_s: got ov=%0b od=%0h ac=%0d want 0/0/0", s_ov, s_od, s_ac);
    end
    checks++;
    if (a_ov !== 1'b0 || a_od !== 32'd0 || a_ac !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_a: got ov=%0b od=%0h ac=%0d want 0/0/0", a_ov, a_od, a_ac);
    end
  endtask

  task automatic test_single_beat();
    int pulses;
    int pulse_at;
    logic [31:0] data;
    pulses   = 0;
    pulse_at = -1;
    data     = '0;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      in_valid = (n == 0);
      in_data  = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
      step();
      if (u_ov) begin
        pulses++;
        pulse_at = n;
        data     = u_od;
      end
      if (n == 6) begin
        checks++;
        if (u_od !== 32'd36) begin
          failures++;
          $display("[TB] FAIL single_hold: got %0d want 36", u_od);
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("[TB] FAIL single_pulses: got %0d want 1", pulses);
    end
    checks++;
    if (pulse_at !== 3) begin
      failures++;
      $display("[TB] FAIL single_latency: got edge %0d want edge 3", pulse_at);
    end
    checks++;
    if (data !== 32'd36) begin
      failures++;
      $display("[TB] FAIL single_data: got %0d want 36", data);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int first_at;
    int last_at;
    pulses   = 0;
    first_at = -1;
    last_at  = -1;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      in_valid = (n < 5);
      in_data  = {8{16'hFFFF}};
      step();
      if (u_ov) begin
        pulses++;
        if (first_at < 0) first_at = n;
        last_at = n;
        checks++;
        if (u_od !== 32'h0007FFF8) begin
          failures++;
          $display("[TB] FAIL b2b_data: got %0h want 7fff8", u_od);
        end
      end
    end
    checks++;
    if (pulses !== 5 || first_at !== 3 || last_at !== 7) begin
      failures++;
      $display("[TB] FAIL b2b_pulses: got count=%0d first=%0d last=%0d want 5/3/7",
               pulses, first_at, last_at);
    end
  endtask

  task automatic test_signed();
    int pulses;
    logic [31:0] res [2];
    int at [2];
    pulses = 0;
    res[0] = '0; res[1] = '0;
    at[0]  = -1; at[1]  = -1;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      in_valid = (n < 2);
      if (n == 0)
        in_data = {16'd8, 16'hFFF9, 16'd6, 16'hFFFB, 16'd4, 16'd3, 16'hFFFE, 16'hFFFF};
      else
        in_data = {8{16'h8000}};
      step();
      if (s_ov) begin
        if (pulses < 2) begin
          res[pulses] = s_od;
          at[pulses]  = n;
        end
        pulses++;
      end
    end
    checks++;
    if (pulses !== 2 || at[0] !== 3 || at[1] !== 4) begin
      failures++;
      $display("[TB] FAIL signed_pulses: got count=%0d at=%0d,%0d want 2 at 3,4", pulses, at[0], at[1]);
    end
    checks++;
    if (res[0] !== 32'd6) begin
      failures++;
      $display("[TB] FAIL signed_mixed: got %0h want 6", res[0]);
    end
    checks++;
    if (res[1] !== 32'hFFFC0000) begin
      failures++;
      $display("[TB] FAIL signed_min: got %0h want fffc0000", res[1]);
    end
  endtask

  task automatic test_accumulate();
    int pulses;
    int pulse_at;
    logic [31:0] data;
    logic [15:0] beat;
    pulses   = 0;
    pulse_at = -1;
    data     = '0;
    do_reset();
    for (int n = 0; n < 16; n++) begin
      in_valid = (n % 3 == 0) && (n <= 9);
      beat     = 16'((n / 3 + 1) * 10);
      in_data  = {112'd0, beat};
      step();
      if (a_ov) begin
        pulses++;
        pulse_at = n;
        data     = a_od;
      end
      if (n == 3 || n == 6 || n == 9) begin
        checks++;
        if (a_ac !== 3'(n / 3)) begin
          failures++;
          $display("[TB] FAIL acc_count_edge%0d: got %0d want %0d", n, a_ac, n / 3);
        end
      end
      if (n == 4) begin
        checks++;
        if (a_ac !== 3'd1) begin
          failures++;
          $display("[TB] FAIL acc_idle_hold: got %0d want 1", a_ac);
        end
      end
      if (n == 12) begin
        checks++;
        if (a_ac !== 3'd0) begin
          failures++;
          $display("[TB] FAIL acc_count_after: got %0d want 0", a_ac);
        end
      end
    end
    checks++;
    if (pulses !== 1 || pulse_at !== 12) begin
      failures++;
      $display("[TB] FAIL acc_pulses: got count=%0d at=%0d want 1 at 12", pulses, pulse_at);
    end
    checks++;
    if (data !== 32'd100) begin
      failures++;
      $display("[TB] FAIL acc_data: got %0d want 100", data);
    end
  endtask

  task automatic test_flush();
    int pulses;
    int pulse_at;
    logic [31:0] data;
    logic [15:0] beat;
    pulses   = 0;
    pulse_at = -1;
    data     = '0;
    do_reset();
    for (int n = 0; n < 15; n++) begin
      in_valid = (n <= 5);
      beat     = (n <= 1) ? 16'd5 : (n == 2) ? 16'd7 : 16'd1;
      in_data  = {112'd0, beat};
      flush    = (n == 5);
      step();
      if (a_ov) begin
        pulses++;
        pulse_at = n;
        data     = a_od;
      end
      if (n == 5) begin
        checks++;
        if (a_ac !== 3'd1) begin
          failures++;
          $display("[TB] FAIL flush_count: got %0d want 1", a_ac);
        end
      end
    end
    flush = 1'b0;
    checks++;
    if (pulses !== 1 || pulse_at !== 8) begin
      failures++;
      $display("[TB] FAIL flush_pulses: got count=%0d at=%0d want 1 at 8", pulses, pulse_at);
    end
    checks++;
    if (data !== 32'd10) begin
      failures++;
      $display("[TB] FAIL flush_data: got %0d want 10", data);
    end
  endtask

  task automatic test_mid_reset();
    int pulses;
    int pulse_at;
    logic [31:0] data;
    logic [15:0] beat;
    pulses   = 0;
    pulse_at = -1;
    data     = '0;
    do_reset();
    for (int n = 0; n < 20; n++) begin
      reset    = (n == 5) || (n == 6);
      in_valid = (n <= 1) || (n == 3) || (n == 4) || (n >= 7 && n <= 10);
      beat     = (n >= 7) ? 16'd3 : 16'd2;
      in_data  = {112'd0, beat};
      step();
      if (a_ov) begin
        pulses++;
        pulse_at = n;
        data     = a_od;
      end
      if (n == 4) begin
        checks++;
        if (a_ac !== 3'd2) begin
          failures++;
          $display("[TB] FAIL midreset_before: got %0d want 2", a_ac);
        end
      end
      if (n == 5) begin
        checks++;
        if (a_ac !== 3'd0 || a_od !== 32'd0) begin
          failures++;
          $display("[TB] FAIL midreset_clear: got ac=%0d od=%0d want 0/0", a_ac, a_od);
        end
      end
    end
    checks++;
    if (pulses !== 1 || pulse_at !== 13) begin
      failures++;
      $display("[TB] FAIL midreset_pulses: got count=%0d at=%0d want 1 at 13", pulses, pulse_at);
    end
    checks++;
    if (data !== 32'd12) begin
      failures++;
      $display("[TB] FAIL midreset_data: got %0d want 12", data);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    in_data  = '0;
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_signed();
    test_accumulate();
    test_flush();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
